// File: rtl/weight_update_engine.sv
// Read-modify-write engine for the weight RAM: streams every column through
// W_new = sat(W - (lr*G) >>> FRAC), one gradient row per column.
module weight_update_engine #(
    parameter int unsigned NROW     = 16,
    parameter int unsigned NCOL     = 16,
    parameter int unsigned BITWIDTH = 18,
    parameter int unsigned FRAC     = 11,
    localparam int unsigned ROWW    = BITWIDTH * NROW,
    localparam int unsigned AW      = $clog2(NCOL + 1) - 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [BITWIDTH-1:0] learnRate,
    input  logic [ROWW-1:0]     gradRow,
    input  logic                gradValid,
    output logic                gradReady,
    output logic [AW-1:0]       gradAddr,
    output logic [AW-1:0]       ramAddrOut,
    input  logic [ROWW-1:0]     ramRowOut,
    output logic [AW-1:0]       ramAddrIn,
    output logic [ROWW-1:0]     ramRowIn,
    output logic                ramWriteEn,
    output logic                busy,
    output logic                done
);

    localparam int unsigned PW = 2 * BITWIDTH;
    localparam int unsigned SW = BITWIDTH + FRAC + 2;
    localparam logic signed [BITWIDTH-1:0] W_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH-1:0] W_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]       S_MAX = SW'(W_MAX);
    localparam logic signed [SW-1:0]       S_MIN = SW'(W_MIN);
    localparam logic [AW-1:0]              COL_LAST = AW'(NCOL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GRAD,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;
    logic [AW-1:0]              col;
    logic [AW-1:0]              col_next;
    logic                       lr_load;
    logic                       grad_accept;
    logic signed [BITWIDTH-1:0] lr_reg;
    logic [ROWW-1:0]            w_reg;
    logic [ROWW-1:0]            g_reg;
    logic [ROWW-1:0]            new_row;

    // State and column register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            col   <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
        end
    end

    // Next-state and column sequencing
    always_comb begin
        state_next  = state;
        col_next    = col;
        lr_load     = 1'b0;
        grad_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_READ;
                    col_next   = '0;
                    lr_load    = 1'b1;
                end
            end
            S_READ:  state_next = S_GRAD;
            S_GRAD: begin
                if (gradValid) begin
                    grad_accept = 1'b1;
                    state_next  = S_CALC;
                end
            end
            S_CALC:  state_next = S_WRITE;
            S_WRITE: begin
                if (col == COL_LAST) begin
                    col_next   = '0;
                    state_next = S_DONE;
                end else begin
                    col_next   = col + AW'(1);
                    state_next = S_READ;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Per-lane scaled subtract with saturation; lanes are fully independent
    for (genvar k = 0; k < NROW; k++) begin : g_lane
        logic signed [BITWIDTH-1:0] w_k;
        logic signed [BITWIDTH-1:0] g_k;
        logic signed [PW-1:0]       p_k;
        logic signed [PW-1:0]       d_k;
        logic signed [SW-1:0]       s_k;
        logic [BITWIDTH-1:0]        r_k;

        always_comb begin
            w_k = w_reg[k*BITWIDTH +: BITWIDTH];
            g_k = g_reg[k*BITWIDTH +: BITWIDTH];
            p_k = PW'(g_k) * PW'(lr_reg);
            d_k = p_k >>> FRAC;
            s_k = SW'(w_k) - SW'(d_k);
            if (s_k > S_MAX) begin
                r_k = W_MAX;
            end else if (s_k < S_MIN) begin
                r_k = W_MIN;
            end else begin
                r_k = s_k[BITWIDTH-1:0];
            end
        end

        assign new_row[k*BITWIDTH +: BITWIDTH] = r_k;
    end

    // Operand capture and registered outputs; strobes track the next state so
    // they line up with the state register and clear asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_reg     <= '0;
            w_reg      <= '0;
            g_reg      <= '0;
            ramRowIn   <= '0;
            ramAddrOut <= '0;
            ramAddrIn  <= '0;
            gradAddr   <= '0;
            gradReady  <= 1'b0;
            ramWriteEn <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (lr_load) begin
                lr_reg <= learnRate;
            end
            if (grad_accept) begin
                w_reg <= ramRowOut;
                g_reg <= gradRow;
            end
            if (state == S_CALC) begin
                ramRowIn <= new_row;
            end
            if (state_next == S_READ || state_next == S_GRAD) begin
                ramAddrOut <= col_next;
            end
            if (state_next == S_GRAD) begin
                gradAddr <= col_next;
            end
            if (state_next == S_WRITE) begin
                ramAddrIn <= col_next;
            end
            gradReady  <= (state_next == S_GRAD);
            ramWriteEn <= (state_next == S_WRITE);
            busy       <= (state_next != S_IDLE);
            done       <= (state_next == S_DONE);
        end
    end

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: behavioural weight RAM on the negedge,
// directed vector table plus stall, start-ignore and mid-pass reset sequences.
module tb_weight_update_engine;

    localparam int unsigned NROW = 16;
    localparam int unsigned NCOL = 16;
    localparam int unsigned BW   = 18;
    localparam int unsigned FRAC = 11;
    localparam int unsigned ROWW = BW * NROW;
    localparam int unsigned AW   = 4;

    typedef logic [ROWW-1:0] row_t;
    typedef struct {
        logic signed [BW-1:0] w;
        logic signed [BW-1:0] g;
        logic signed [BW-1:0] lr;
        logic signed [BW-1:0] exp_w;
    } vec_t;

    logic            clk;
    logic            reset;
    logic            start;
    logic [BW-1:0]   learnRate;
    row_t            gradRow;
    logic            gradValid;
    logic            gradReady;
    logic [AW-1:0]   gradAddr;
    logic [AW-1:0]   ramAddrOut;
    row_t            ramRowOut;
    logic [AW-1:0]   ramAddrIn;
    row_t            ramRowIn;
    logic            ramWriteEn;
    logic            busy;
    logic            done;

    weight_update_engine #(
        .NROW(NROW), .NCOL(NCOL), .BITWIDTH(BW), .FRAC(FRAC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .learnRate(learnRate),
        .gradRow(gradRow), .gradValid(gradValid), .gradReady(gradReady),
        .gradAddr(gradAddr), .ramAddrOut(ramAddrOut), .ramRowOut(ramRowOut),
        .ramAddrIn(ramAddrIn), .ramRowIn(ramRowIn), .ramWriteEn(ramWriteEn),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    row_t mem      [NCOL];
    row_t fill_mem [NCOL];
    row_t grad_mem [NCOL];
    row_t snap     [NCOL];
    logic fill_en;

    // Weight RAM: negedge read/write, bulk preload from the bench
    always @(negedge clk) begin
        if (fill_en) begin
            for (int r = 0; r < NCOL; r++) mem[r] <= fill_mem[r];
        end else if (ramWriteEn) begin
            mem[ramAddrIn] <= ramRowIn;
        end else begin
            ramRowOut <= mem[ramAddrOut];
        end
    end

    int busy_cnt = 0;
    int done_cnt = 0;
    int wr_q[$];
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (ramWriteEn) wr_q.push_back(int'(ramAddrIn));
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_row(input string name, input row_t act, input row_t exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic signed [BW-1:0] upd(input logic signed [BW-1:0] w,
                                                 input logic signed [BW-1:0] g,
                                                 input logic signed [BW-1:0] lr);
        longint p, d, s, scale;
        scale = longint'(1) << FRAC;
        p = longint'(g) * longint'(lr);
        d = (p >= 0) ? (p / scale) : -((-p + scale - 1) / scale);
        s = longint'(w) - d;
        if (s > 131071) s = 131071;
        if (s < -131072) s = -131072;
        return BW'(s);
    endfunction

    function automatic row_t model_row(input row_t w, input row_t g, input logic signed [BW-1:0] lr);
        row_t res;
        for (int k = 0; k < NROW; k++)
            res[k*BW +: BW] = upd(w[k*BW +: BW], g[k*BW +: BW], lr);
        return res;
    endfunction

    task automatic do_fill();
        @(posedge clk); #1;
        fill_en = 1'b1;
        @(posedge clk); #1;
        fill_en = 1'b0;
    endtask

    int base_busy, base_done, base_wr, stall_seen, stall_bad;

    // One pass: start, feed gradients, optionally stall/poke start/reset at a column
    task automatic run_pass(input logic [BW-1:0] lr, input int stall_col, input int stall_len,
                            input bit poke_start, input int rst_col, output bit finished);
        base_busy  = busy_cnt;
        base_done  = done_cnt;
        base_wr    = wr_q.size();
        stall_seen = 0;
        stall_bad  = 0;
        finished   = 1'b0;
        @(posedge clk); #1;
        learnRate = lr;
        start     = 1'b1;
        gradValid = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        learnRate = ~lr;
        for (int cyc = 0; cyc < 500; cyc++) begin
            gradRow   = grad_mem[gradAddr];
            gradValid = 1'b1;
            if (poke_start) start = (cyc == 10 || cyc == 40);
            if (gradReady && int'(gradAddr) == stall_col && stall_seen < stall_len) begin
                gradValid = 1'b0;
                stall_seen++;
                if (int'(ramAddrOut) != stall_col || ramWriteEn) stall_bad++;
            end
            if (rst_col >= 0 && ramWriteEn && int'(ramAddrIn) == rst_col) begin
                reset = 1'b1;
                return;
            end
            if (done) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        if (!finished) chk("pass_timeout", 0, 1);
    endtask

    task automatic chk_writes(input string name);
        chk({name, "_wr_count"}, wr_q.size() - base_wr, NCOL);
        for (int i = 0; i < NCOL && base_wr + i < wr_q.size(); i++)
            chk($sformatf("%s_wr_addr%0d", name, i), wr_q[base_wr + i], i);
    endtask

    vec_t vecs[8];
    bit   fin;
    row_t exp_row;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        learnRate = '0;
        gradRow   = '0;
        gradValid = 1'b0;
        fill_en   = 1'b0;

        vecs[0] = '{w:  18'sd2048,   g:  18'sd4096,  lr:  18'sd1024, exp_w:  18'sd0};
        vecs[1] = '{w: -18'sd131072, g:  18'sd2048,  lr:  18'sd2048, exp_w: -18'sd131072};
        vecs[2] = '{w:  18'sd131071, g: -18'sd4096,  lr:  18'sd2048, exp_w:  18'sd131071};
        vecs[3] = '{w:  18'sd100,    g: -18'sd1,     lr:  18'sd1,    exp_w:  18'sd101};
        vecs[4] = '{w:  18'sd100,    g:  18'sd1,     lr:  18'sd1,    exp_w:  18'sd100};
        vecs[5] = '{w:  18'sd0,      g: -18'sd2048,  lr: -18'sd2048, exp_w: -18'sd2048};
        vecs[6] = '{w:  18'sd5,      g:  18'sd3,     lr:  18'sd1000, exp_w:  18'sd4};
        vecs[7] = '{w:  18'sd5,      g: -18'sd3,     lr:  18'sd1000, exp_w:  18'sd7};

        #1;
        chk("reset_outputs", longint'({gradReady, ramWriteEn, busy, done, gradAddr, ramAddrOut, ramAddrIn}), 0);
        chk("reset_rowin", longint'(ramRowIn == '0), 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Uniform-row vectors: every lane of every row should land on exp_w
        for (int v = 0; v < 8; v++) begin
            for (int r = 0; r < NCOL; r++) begin
                fill_mem[r] = {NROW{vecs[v].w}};
                grad_mem[r] = {NROW{vecs[v].g}};
            end
            do_fill();
            run_pass(vecs[v].lr, -1, 0, 1'b0, -1, fin);
            for (int r = 0; r < NCOL; r++)
                chk_row($sformatf("vec%0d_row%0d", v, r), mem[r], {NROW{vecs[v].exp_w}});
        end

        // Full pass with varied data, gradValid held high
        for (int r = 0; r < NCOL; r++)
            for (int k = 0; k < NROW; k++) begin
                fill_mem[r][k*BW +: BW] = BW'(r * 7919 + k * 3331);
                grad_mem[r][k*BW +: BW] = BW'(r * 5003 - k * 2741 + 12345);
            end
        do_fill();
        run_pass(BW'(1500), -1, 0, 1'b0, -1, fin);
        chk("full_busy_cycles", busy_cnt - base_busy, 65);
        chk("full_done_pulses", done_cnt - base_done, 1);
        chk_writes("full");
        for (int r = 0; r < NCOL; r++)
            chk_row($sformatf("full_row%0d", r), mem[r], model_row(fill_mem[r], grad_mem[r], BW'(1500)));

        // Stall of 5 cycles at column 3 with stray start pulses
        do_fill();
        run_pass(-BW'(777), 3, 5, 1'b1, -1, fin);
        chk("stall_cycles", stall_seen, 5);
        chk("stall_addr_or_write", stall_bad, 0);
        chk("stall_busy_cycles", busy_cnt - base_busy, 70);
        chk("stall_done_pulses", done_cnt - base_done, 1);
        chk_writes("stall");
        for (int r = 0; r < NCOL; r++)
            chk_row($sformatf("stall_row%0d", r), mem[r], model_row(fill_mem[r], grad_mem[r], -BW'(777)));
        chk("stall_idle_after", longint'(busy), 0);

        // Reset during the WRITE of column 7
        do_fill();
        run_pass(BW'(900), -1, 0, 1'b0, 7, fin);
        #1;
        chk("rst_write_drop", longint'(ramWriteEn), 0);
        chk("rst_outputs", longint'({gradReady, busy, done, gradAddr, ramAddrOut, ramAddrIn}), 0);
        chk("rst_rowin", longint'(ramRowIn == '0), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_writes_before", wr_q.size() - base_wr, 7);
        for (int r = 0; r < NCOL; r++) begin
            exp_row = (r < 7) ? model_row(fill_mem[r], grad_mem[r], BW'(900)) : fill_mem[r];
            chk_row($sformatf("rst_row%0d", r), mem[r], exp_row);
        end

        // Fresh pass after reset starts from column 0
        for (int r = 0; r < NCOL; r++) snap[r] = mem[r];
        run_pass(BW'(300), -1, 0, 1'b0, -1, fin);
        chk("post_busy_cycles", busy_cnt - base_busy, 65);
        chk_writes("post");
        for (int r = 0; r < NCOL; r++)
            chk_row($sformatf("post_row%0d", r), mem[r], model_row(snap[r], grad_mem[r], BW'(300)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
